// File: rtl/datamover_job_sequencer_pkg.sv
// Shared types for the datamover job sequencer: FSM state encoding and the
// 13-register job descriptor layout (register 0 occupies the lowest 32 bits).
package datamover_job_sequencer_pkg;

  localparam int unsigned JOB_REGS = 13;
  localparam int unsigned REG_BITS = 32;
  localparam int unsigned JOB_BITS = JOB_REGS * REG_BITS;

  localparam int unsigned REG_IN_BASE       = 0;
  localparam int unsigned REG_OUT_BASE      = 1;
  localparam int unsigned REG_TOT_LEN       = 2;
  localparam int unsigned REG_IN_D0_LEN     = 3;
  localparam int unsigned REG_IN_D0_STRIDE  = 4;
  localparam int unsigned REG_IN_D1_LEN     = 5;
  localparam int unsigned REG_IN_D1_STRIDE  = 6;
  localparam int unsigned REG_IN_D2_STRIDE  = 7;
  localparam int unsigned REG_OUT_D0_LEN    = 8;
  localparam int unsigned REG_OUT_D0_STRIDE = 9;
  localparam int unsigned REG_OUT_D1_LEN    = 10;
  localparam int unsigned REG_OUT_D1_STRIDE = 11;
  localparam int unsigned REG_OUT_D2_STRIDE = 12;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_CHECK,
    SEQ_START,
    SEQ_SETTLE,
    SEQ_RUN,
    SEQ_FINISHED
  } seq_state_e;

  // Declared MSB-first so that in_base lands in bits [31:0].
  typedef struct packed {
    logic [31:0] out_d2_stride;
    logic [31:0] out_d1_stride;
    logic [31:0] out_d1_len;
    logic [31:0] out_d0_stride;
    logic [31:0] out_d0_len;
    logic [31:0] in_d2_stride;
    logic [31:0] in_d1_stride;
    logic [31:0] in_d1_len;
    logic [31:0] in_d0_stride;
    logic [31:0] in_d0_len;
    logic [31:0] tot_len;
    logic [31:0] out_base;
    logic [31:0] in_base;
  } job_desc_t;

endpackage

// File: rtl/datamover_job_sequencer_cfg_mux.sv
// N_JOBS-way combinational descriptor select for the datamover job sequencer.
module datamover_job_cfg_mux
  import datamover_job_sequencer_pkg::*;
#(
  parameter int unsigned N_JOBS = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic [N_JOBS*JOB_BITS-1:0] job_cfg_i,
  input  logic [IDX_W-1:0]           idx_i,
  output job_desc_t                  desc_o
);

  always_comb begin
    desc_o = job_cfg_i[JOB_BITS-1:0];
    for (int j = 0; j < int'(N_JOBS); j++) begin
      if (int'(idx_i) == j) desc_o = job_cfg_i[j*JOB_BITS +: JOB_BITS];
    end
  end

endmodule

// File: rtl/datamover_job_sequencer.sv
// Job sequencer for the datamover HWPE: walks up to N_JOBS descriptors, pulses
// streamer valid, settles, then waits for full drain. Optional macro
// DATAMOVER_SEQ_PERF_CNT_EN adds a saturating busy-cycle counter perf_cycles_o.
// Handshake: src/sink valid is a single-cycle pulse in START; the job is
// considered drained only when all five streamer flags are high in one cycle.
module datamover_job_sequencer
  import datamover_job_sequencer_pkg::*;
#(
  parameter int unsigned N_JOBS     = 4,
  parameter int unsigned N_JOB_REGS = JOB_REGS,
  parameter int unsigned GAP_W      = 4,
  localparam int unsigned CNT_W     = $clog2(N_JOBS + 1),
  localparam int unsigned IDX_W     = (N_JOBS > 1) ? $clog2(N_JOBS) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           start_i,
  input  logic [CNT_W-1:0]               n_jobs_i,
  input  logic [GAP_W-1:0]               gap_i,
  input  logic [N_JOBS*N_JOB_REGS*32-1:0] job_cfg_i,
  input  logic                           src_done_i,
  input  logic                           sink_done_i,
  input  logic                           src_ready_i,
  input  logic                           sink_ready_i,
  input  logic                           tcdm_fifo_empty_i,
  output logic [N_JOB_REGS*32-1:0]       job_cfg_o,
  output logic                           src_valid_o,
  output logic                           sink_valid_o,
  output logic                           busy_o,
  output logic [IDX_W-1:0]               job_idx_o,
  output logic                           done_o,
  output seq_state_e                     state_o
`ifdef DATAMOVER_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                    perf_cycles_o
`endif
);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  job_desc_t        cur_desc;
  logic [CNT_W-1:0] eff_n;
  logic [GAP_W-1:0] gap_load;
  logic             is_last;
  logic             drained;

  datamover_job_cfg_mux #(
    .N_JOBS (N_JOBS),
    .IDX_W  (IDX_W)
  ) i_cfg_mux (
    .job_cfg_i (job_cfg_i),
    .idx_i     (idx_q),
    .desc_o    (cur_desc)
  );

  assign eff_n    = (n_jobs_i > CNT_W'(N_JOBS)) ? CNT_W'(N_JOBS) : n_jobs_i;
  assign gap_load = (gap_i == '0) ? '0 : gap_i - GAP_W'(1);
  assign is_last  = (CNT_W'(idx_q) + CNT_W'(1)) == eff_n;
  assign drained  = src_done_i & sink_done_i & tcdm_fifo_empty_i & src_ready_i & sink_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SEQ_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    src_valid_o  = 1'b0;
    sink_valid_o = 1'b0;
    done_o       = 1'b0;
    busy_o       = (state_q != SEQ_IDLE);

    if (clear_i) begin
      state_d = SEQ_IDLE;
      idx_d   = '0;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        SEQ_IDLE: begin
          if (start_i) begin
            idx_d   = '0;
            state_d = (eff_n == '0) ? SEQ_FINISHED : SEQ_CHECK;
          end
        end
        // Zero-length jobs are skipped without touching the streamer.
        SEQ_CHECK: begin
          if (cur_desc.tot_len == '0) begin
            if (is_last) state_d = SEQ_FINISHED;
            else         idx_d   = idx_q + IDX_W'(1);
          end else begin
            state_d = SEQ_START;
          end
        end
        SEQ_START: begin
          gap_d   = gap_load;
          state_d = SEQ_SETTLE;
        end
        SEQ_SETTLE: begin
          if (gap_q == '0) state_d = SEQ_RUN;
          else             gap_d   = gap_q - GAP_W'(1);
        end
        SEQ_RUN: begin
          if (drained) begin
            if (is_last) begin
              state_d = SEQ_FINISHED;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              state_d = SEQ_CHECK;
            end
          end
        end
        SEQ_FINISHED: begin
          state_d = SEQ_IDLE;
          idx_d   = '0;
        end
        default: state_d = SEQ_IDLE;
      endcase
    end

    if (state_q == SEQ_START) begin
      src_valid_o  = 1'b1;
      sink_valid_o = 1'b1;
    end
    if (state_q == SEQ_FINISHED) done_o = 1'b1;
  end

  assign job_cfg_o = cur_desc;
  assign job_idx_o = idx_q;
  assign state_o   = state_q;

`ifdef DATAMOVER_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else if (clear_i) begin
      perf_q <= '0;
    end else if (state_q == SEQ_IDLE && start_i) begin
      perf_q <= '0;
    end else if (busy_o && perf_q != 32'hFFFF_FFFF) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_datamover_job_sequencer.sv
// Scoreboard bench for datamover_job_sequencer with a simple streamer drain model.
module tb_datamover_job_sequencer;
  import datamover_job_sequencer_pkg::*;

  localparam int JB = 416;
  localparam int W  = 8;
  localparam logic [W-1:0] EV_DONE = 8'h40;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            clear_i = 1'b0;
  logic            start_i = 1'b0;
  logic [2:0]      n_jobs_i = '0;
  logic [3:0]      gap_i = '0;
  logic [4*JB-1:0] job_cfg_i = '0;
  logic            src_done_i, sink_done_i, src_ready_i, sink_ready_i, tcdm_fifo_empty_i;
  logic [JB-1:0]   job_cfg_o;
  logic            src_valid_o, sink_valid_o, busy_o, done_o;
  logic [1:0]      job_idx_o;
  seq_state_e      state_o;
`ifdef DATAMOVER_SEQ_PERF_CNT_EN
  logic [31:0]     perf_cycles_o;
`endif

  datamover_job_sequencer #(.N_JOBS(4), .N_JOB_REGS(13), .GAP_W(4)) dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .clear_i           (clear_i),
    .start_i           (start_i),
    .n_jobs_i          (n_jobs_i),
    .gap_i             (gap_i),
    .job_cfg_i         (job_cfg_i),
    .src_done_i        (src_done_i),
    .sink_done_i       (sink_done_i),
    .src_ready_i       (src_ready_i),
    .sink_ready_i      (sink_ready_i),
    .tcdm_fifo_empty_i (tcdm_fifo_empty_i),
    .job_cfg_o         (job_cfg_o),
    .src_valid_o       (src_valid_o),
    .sink_valid_o      (sink_valid_o),
    .busy_o            (busy_o),
    .job_idx_o         (job_idx_o),
    .done_o            (done_o),
    .state_o           (state_o)
`ifdef DATAMOVER_SEQ_PERF_CNT_EN
    ,
    .perf_cycles_o     (perf_cycles_o)
`endif
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  // streamer model: flags drop on a valid pulse and return run_len cycles later
  int   drain_cnt = 0;
  int   run_len = 10;
  logic hold_sink_ready = 1'b0;

  always @(negedge clk_i) begin
    if (src_valid_o) drain_cnt = run_len;
    else if (drain_cnt > 0) drain_cnt = drain_cnt - 1;
  end

  assign src_done_i        = (drain_cnt == 0);
  assign sink_done_i       = (drain_cnt == 0);
  assign src_ready_i       = (drain_cnt == 0);
  assign tcdm_fifo_empty_i = (drain_cnt == 0);
  assign sink_ready_i      = (drain_cnt == 0) && !hold_sink_ready;

  // scoreboard
  logic [W-1:0]  exp_q[$];
  logic [JB-1:0] desc_tb [4];
  int            n_tests = 0;
  int            n_fail = 0;
  logic          prev_valid = 1'b0;
  logic [W-1:0]  mon_got, mon_exp;
  logic          mon_ok;
  int            busy_meas = 0;

  always @(negedge clk_i) begin
    if (rst_ni && (src_valid_o || sink_valid_o || done_o)) begin
      n_tests = n_tests + 1;
      mon_got = (src_valid_o || sink_valid_o) ? (8'h80 | 8'(job_idx_o)) : EV_DONE;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL sb_event: got event %h, expected no event", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_ok  = (mon_got == mon_exp);
        if (mon_got[7])
          mon_ok = mon_ok && src_valid_o && sink_valid_o && !prev_valid && !done_o
                   && (job_cfg_o == desc_tb[job_idx_o]);
        if (!mon_ok) begin
          n_fail = n_fail + 1;
          $display("FAIL sb_event: got %h (src %b sink %b prev %b cfg_ok %b), expected %h",
                   mon_got, src_valid_o, sink_valid_o, prev_valid,
                   job_cfg_o == desc_tb[job_idx_o], mon_exp);
        end
      end
    end
    prev_valid = src_valid_o;
    if (busy_o) busy_meas = busy_meas + 1;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic build_descs(input logic [31:0] tl0, tl1, tl2, tl3);
    logic [31:0] tl [4];
    tl[0] = tl0; tl[1] = tl1; tl[2] = tl2; tl[3] = tl3;
    for (int j = 0; j < 4; j++) begin
      for (int r = 0; r < 13; r++) desc_tb[j][r*32 +: 32] = {16'hC0DE, 8'(j), 8'(r)};
      desc_tb[j][REG_TOT_LEN*32 +: 32] = tl[j];
      job_cfg_i[j*JB +: JB] = desc_tb[j];
    end
  endtask

  task automatic push_run(input int n);
    int eff;
    eff = (n > 4) ? 4 : n;
    for (int j = 0; j < eff; j++)
      if (desc_tb[j][REG_TOT_LEN*32 +: 32] != 0) exp_q.push_back(8'h80 | 8'(j));
    exp_q.push_back(EV_DONE);
  endtask

  task automatic do_run(input int n, input int g, input int rl, input bit check_lat, input string name);
    int cnt;
    n_jobs_i = 3'(n);
    gap_i    = 4'(g);
    run_len  = rl;
    push_run(n);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    if (check_lat) begin
      cnt = 1;
      while (!src_valid_o && cnt < 50) begin tick(1); cnt++; end
      check({name, "_start_to_valid"}, 64'(cnt), 64'd2);
      cnt = 0;
      while (state_o != SEQ_RUN && cnt < 50) begin tick(1); cnt++; end
      check({name, "_valid_to_run"}, 64'(cnt), 64'((g == 0 ? 1 : g) + 1));
    end
    cnt = 0;
    while (!done_o && cnt < 2000) begin tick(1); cnt++; end
    check({name, "_done_seen"}, 64'(done_o), 64'd1);
    tick(1);
    check({name, "_idle_after"}, {busy_o, 6'(job_idx_o)}, 64'd0);
  endtask

  // directed sequence
  initial begin
    int cnt;
    build_descs(16, 16, 16, 16);
    tick(3);
    rst_ni = 1'b1;
    tick(1);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_valid", {src_valid_o, sink_valid_o, done_o}, 64'd0);
    check("rst_idx", 64'(job_idx_o), 64'd0);
    check("rst_cfg", 64'(job_cfg_o == desc_tb[0]), 64'd1);
    check("rst_state", 64'(state_o), 64'(SEQ_IDLE));

    // three jobs, gap 2
    do_run(3, 2, 10, 1'b1, "three_jobs");

    // job 1 skipped
    build_descs(16, 0, 16, 16);
    do_run(4, 1, 6, 1'b0, "skip_job1");

    // zero jobs: straight to FINISHED
    build_descs(16, 16, 16, 16);
    n_jobs_i = 3'd0;
    exp_q.push_back(EV_DONE);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    check("zero_jobs_done_lat", 64'(done_o), 64'd1);
    tick(2);
    check("zero_jobs_idle", 64'(busy_o), 64'd0);

    // n_jobs above N_JOBS clamps to 4
    do_run(7, 1, 5, 1'b0, "clamp");

    // clear during SETTLE of job 1
    n_jobs_i = 3'd3;
    gap_i    = 4'd3;
    run_len  = 6;
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h81);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    cnt = 0;
    while (!(state_o == SEQ_SETTLE && job_idx_o == 2'd1) && cnt < 200) begin tick(1); cnt++; end
    check("clr_reached_settle", 64'(state_o), 64'(SEQ_SETTLE));
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
    check("clr_state", 64'(state_o), 64'(SEQ_IDLE));
    check("clr_busy_idx_done", {busy_o, job_idx_o, done_o}, 64'd0);
    tick(20);
    check("clr_no_done", 64'(exp_q.size()), 64'd0);
    do_run(3, 2, 8, 1'b1, "after_clear");

    // sink_ready held low blocks the advance
    hold_sink_ready = 1'b1;
    n_jobs_i = 3'd1;
    gap_i    = 4'd1;
    run_len  = 4;
    push_run(1);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    cnt = 0;
    while (state_o != SEQ_RUN && cnt < 50) begin tick(1); cnt++; end
    tick(8);
    check("hold_in_run", 64'(state_o), 64'(SEQ_RUN));
    hold_sink_ready = 1'b0;
    tick(1);
    check("advance_1cyc", 64'(state_o), 64'(SEQ_FINISHED));
    tick(2);

    // gap 0 behaves like gap 1
    do_run(2, 0, 5, 1'b1, "gap0");

`ifdef DATAMOVER_SEQ_PERF_CNT_EN
    busy_meas = 0;
    do_run(2, 1, 5, 1'b0, "perf");
    check("perf_count", 64'(perf_cycles_o), 64'(busy_meas));
    tick(3);
    check("perf_hold", 64'(perf_cycles_o), 64'(busy_meas));
`endif

    tick(5);
    check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
